// File: rtl/tlu_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tlu_run_pkg
// Shared definitions for the TLU run controller: state encoding, default
// counter widths and the channel-readiness helper used by the drain logic.
// ---------------------------------------------------------------------------
package tlu_run_pkg;

  localparam int DEF_CNT_WIDTH   = 32;
  localparam int DEF_DRAIN_WIDTH = 16;
  localparam int N_CHAN          = 6;

  // Encoding is visible to software through the STATE output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } tlu_state_t;

  // A disabled channel is treated as ready so it can never block a drain.
  function automatic logic chan_all_ready(input logic [N_CHAN-1:0] ready,
                                          input logic [N_CHAN-1:0] en);
    return &(ready | ~en);
  endfunction

endpackage

// File: rtl/tlu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// tlu_run_ctrl_if
// Command, configuration, datapath-status and run-status signals of the TLU
// run controller.
//   master : run-control software side plus the trigger datapath / DUT status
//   slave  : the run controller itself
// ---------------------------------------------------------------------------
interface tlu_run_ctrl_if
  import tlu_run_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int DRAIN_WIDTH = DEF_DRAIN_WIDTH
);

  logic                   CMD_START;
  logic                   CMD_STOP;
  logic [CNT_WIDTH-1:0]   CONF_MAX_TRIGGERS;
  logic [CNT_WIDTH-1:0]   CONF_RUN_TIME;
  logic [DRAIN_WIDTH-1:0] CONF_DRAIN_TIMEOUT;
  logic [N_CHAN-1:0]      CONF_EN_OUTPUT;
  logic                   TRIG_PULSE;
  logic [N_CHAN-1:0]      DUT_READY;
  logic                   DATA_EMPTY;

  logic                   RUN_START;
  logic                   TRIG_ENABLE;
  logic [1:0]             STATE;
  logic [CNT_WIDTH-1:0]   RUN_TRIG_CNT;
  logic [CNT_WIDTH-1:0]   RUN_TIME_CNT;
  logic                   DONE;
  logic                   DRAIN_TIMEOUT;

  modport master (
    output CMD_START, CMD_STOP, CONF_MAX_TRIGGERS, CONF_RUN_TIME,
           CONF_DRAIN_TIMEOUT, CONF_EN_OUTPUT, TRIG_PULSE, DUT_READY, DATA_EMPTY,
    input  RUN_START, TRIG_ENABLE, STATE, RUN_TRIG_CNT, RUN_TIME_CNT, DONE,
           DRAIN_TIMEOUT
  );

  modport slave (
    input  CMD_START, CMD_STOP, CONF_MAX_TRIGGERS, CONF_RUN_TIME,
           CONF_DRAIN_TIMEOUT, CONF_EN_OUTPUT, TRIG_PULSE, DUT_READY, DATA_EMPTY,
    output RUN_START, TRIG_ENABLE, STATE, RUN_TRIG_CNT, RUN_TIME_CNT, DONE,
           DRAIN_TIMEOUT
  );

endinterface

// File: rtl/tlu_sat_counter.sv
// ---------------------------------------------------------------------------
// tlu_sat_counter
// Up-counter with synchronous clear (priority over enable) that sticks at
// all-ones instead of wrapping.
//   clk   : clock
//   rst_n : asynchronous active-low reset (already deassertion-synchronised)
//   clr   : clear to zero
//   en    : count enable
//   cnt   : registered count
// ---------------------------------------------------------------------------
module tlu_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + ONE;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/tlu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tlu_run_ctrl
// Run sequencer for the TLU: IDLE -> ARM -> RUN -> DRAIN -> IDLE.
// ARM lasts one cycle, pulses RUN_START, snapshots the run limits and clears
// the counters and status flags. RUN gates trigger generation and ends on a
// stop command, trigger limit or run-time limit. DRAIN waits for the record
// FIFO to empty and the enabled DUT channels to be ready, with an optional
// timeout.
//   CLK40 : clock
//   RST_N : asynchronous active-low reset (deassertion synchronised here)
//   bus   : commands, configuration, datapath status in; run status out
// ---------------------------------------------------------------------------
module tlu_run_ctrl
  import tlu_run_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int DRAIN_WIDTH = DEF_DRAIN_WIDTH
) (
  input logic           CLK40,
  input logic           RST_N,
  tlu_run_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DRAIN_WIDTH-1:0] DRAIN_ONE = DRAIN_WIDTH'(1);

  // Reset asserts immediately but releases only on a clock edge, two flops
  // deep, so no register leaves reset on a metastable release.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_reg[1];

  tlu_state_t             state_reg, state_next;
  logic [CNT_WIDTH-1:0]   max_trig_reg;
  logic [CNT_WIDTH-1:0]   run_time_reg;
  logic [DRAIN_WIDTH-1:0] drain_to_reg;
  logic                   run_start_reg;
  logic                   trig_enable_reg;
  logic                   done_reg, done_next;
  logic                   timeout_reg, timeout_next;

  logic [CNT_WIDTH-1:0]   trig_cnt, time_cnt;
  logic [DRAIN_WIDTH-1:0] drain_cnt;

  logic arm_entry;
  logic trig_hit, time_hit, stop_run;
  logic drain_ok, drain_to_hit;

  // Limits compare against count+1 so the state change lands on the edge
  // that completes the Nth trigger / Nth RUN cycle / Nth DRAIN cycle.
  assign trig_hit     = (max_trig_reg != '0) && bus.TRIG_PULSE &&
                        ((trig_cnt + CNT_ONE) == max_trig_reg);
  assign time_hit     = (run_time_reg != '0) &&
                        ((time_cnt + CNT_ONE) == run_time_reg);
  assign stop_run     = bus.CMD_STOP || trig_hit || time_hit;
  assign drain_ok     = bus.DATA_EMPTY &&
                        chan_all_ready(bus.DUT_READY, bus.CONF_EN_OUTPUT);
  assign drain_to_hit = (drain_to_reg != '0) &&
                        ((drain_cnt + DRAIN_ONE) == drain_to_reg);

  always_comb begin
    state_next   = state_reg;
    done_next    = done_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.CMD_START) state_next = ST_ARM;
      end
      ST_ARM: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // Stop outranks a restart request in the same cycle.
        if (stop_run)           state_next = ST_DRAIN;
        else if (bus.CMD_START) state_next = ST_ARM;
      end
      ST_DRAIN: begin
        if (drain_ok || bus.CMD_STOP) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (drain_to_hit) begin
          state_next   = ST_IDLE;
          done_next    = 1'b1;
          timeout_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Entering ARM starts a fresh run: status flags go back to zero.
    if (state_next == ST_ARM) begin
      done_next    = 1'b0;
      timeout_next = 1'b0;
    end
  end

  assign arm_entry = (state_next == ST_ARM);

  always_ff @(posedge CLK40 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg       <= ST_IDLE;
      run_start_reg   <= 1'b0;
      trig_enable_reg <= 1'b0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      max_trig_reg    <= '0;
      run_time_reg    <= '0;
      drain_to_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      // Decoded from the next state so the outputs line up with STATE.
      run_start_reg   <= (state_next == ST_ARM);
      trig_enable_reg <= (state_next == ST_RUN);
      done_reg        <= done_next;
      timeout_reg     <= timeout_next;
      if (state_reg == ST_ARM) begin
        max_trig_reg <= bus.CONF_MAX_TRIGGERS;
        run_time_reg <= bus.CONF_RUN_TIME;
        drain_to_reg <= bus.CONF_DRAIN_TIMEOUT;
      end
    end
  end

  tlu_sat_counter #(.WIDTH(CNT_WIDTH)) u_trig_cnt (
    .clk   (CLK40),
    .rst_n (rst_n_int),
    .clr   (arm_entry),
    .en    ((state_reg == ST_RUN) && bus.TRIG_PULSE),
    .cnt   (trig_cnt)
  );

  tlu_sat_counter #(.WIDTH(CNT_WIDTH)) u_time_cnt (
    .clk   (CLK40),
    .rst_n (rst_n_int),
    .clr   (arm_entry),
    .en    (state_reg == ST_RUN),
    .cnt   (time_cnt)
  );

  tlu_sat_counter #(.WIDTH(DRAIN_WIDTH)) u_drain_cnt (
    .clk   (CLK40),
    .rst_n (rst_n_int),
    .clr   (arm_entry),
    .en    (state_reg == ST_DRAIN),
    .cnt   (drain_cnt)
  );

  assign bus.RUN_START     = run_start_reg;
  assign bus.TRIG_ENABLE   = trig_enable_reg;
  assign bus.STATE         = state_reg;
  assign bus.RUN_TRIG_CNT  = trig_cnt;
  assign bus.RUN_TIME_CNT  = time_cnt;
  assign bus.DONE          = done_reg;
  assign bus.DRAIN_TIMEOUT = timeout_reg;

endmodule

// File: doc/tlu_run_ctrl.md
TLU_RUN_CTRL -- requirements
Module: tlu_run_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the run trigger counter, run time counter and their limits.
REQ-002 Parameter DRAIN_WIDTH, default 16: width of the drain counter and drain timeout.
REQ-003 CLK40  in  1  single clock; every register is clocked on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 CMD_START  in  1  one-cycle start-run pulse.
REQ-006 CMD_STOP  in  1  one-cycle stop-run pulse.
REQ-007 CONF_MAX_TRIGGERS  in  CNT_WIDTH  trigger limit per run; 0 = unlimited.
REQ-008 CONF_RUN_TIME  in  CNT_WIDTH  run length in CLK40 cycles; 0 = unlimited.
REQ-009 CONF_DRAIN_TIMEOUT  in  DRAIN_WIDTH  drain limit in cycles; 0 = no timeout.
REQ-010 CONF_EN_OUTPUT  in  6  enabled DUT output channels.
REQ-011 TRIG_PULSE  in  1  accepted trigger pulse from the trigger datapath.
REQ-012 DUT_READY  in  6  per-channel ready flag from the DUT transmitters.
REQ-013 DATA_EMPTY  in  1  high when the trigger-record FIFO write side holds no data.
REQ-014 RUN_START  out  1  one-cycle pulse that clears the timestamp and trigger ID in the datapath.
REQ-015 TRIG_ENABLE  out  1  trigger generation gate.
REQ-016 STATE  out  2  current state: IDLE=0, ARM=1, RUN=2, DRAIN=3.
REQ-017 RUN_TRIG_CNT  out  CNT_WIDTH  number of triggers counted in the current or last run.
REQ-018 RUN_TIME_CNT  out  CNT_WIDTH  number of RUN cycles in the current or last run.
REQ-019 DONE  out  1  sticky flag: the last run has ended.
REQ-020 DRAIN_TIMEOUT  out  1  sticky flag: the last drain ended by timeout.

Function
REQ-021 All outputs SHALL be registered; TRIG_ENABLE SHALL be 1 exactly in the cycles where STATE=RUN.
REQ-022 IDLE: CMD_START SHALL move to ARM; CMD_STOP and TRIG_PULSE SHALL be ignored.
REQ-023 ARM (one cycle): RUN_START=1; CONF_MAX_TRIGGERS, CONF_RUN_TIME and CONF_DRAIN_TIMEOUT latched; counters, DONE and DRAIN_TIMEOUT cleared; next state RUN.
REQ-024 RUN: RUN_TIME_CNT SHALL increment every cycle; RUN_TRIG_CNT SHALL increment on each TRIG_PULSE; both SHALL saturate at all-ones.
REQ-025 RUN SHALL go to DRAIN on CMD_STOP, or when a TRIG_PULSE makes RUN_TRIG_CNT equal a nonzero latched trigger limit, or when RUN_TIME_CNT+1 equals a nonzero latched run time.
REQ-026 RUN with CMD_START and no stop condition SHALL go to ARM (restart); a simultaneous stop condition SHALL win, giving DRAIN.
REQ-027 A TRIG_PULSE in the cycle a stop condition fires SHALL be counted; TRIG_PULSE outside RUN SHALL NOT be counted.
REQ-028 DRAIN: the drain counter SHALL increment each cycle.
REQ-029 DRAIN SHALL go to IDLE with DONE=1 when DATA_EMPTY=1 and (DUT_READY | ~CONF_EN_OUTPUT) is all ones.
REQ-030 DRAIN SHALL go to IDLE with DONE=1 and DRAIN_TIMEOUT=1 when the drain counter+1 equals a nonzero latched drain timeout; the normal exit SHALL take precedence in the same cycle.
REQ-031 CMD_STOP in DRAIN SHALL force IDLE with DONE=1 and DRAIN_TIMEOUT unchanged; CMD_START in DRAIN SHALL be ignored.
REQ-032 Config input changes after ARM SHALL have no effect until the next ARM.
REQ-033 Counters SHALL hold their values in IDLE and DRAIN so software can read them.

Reset
REQ-034 While RST_N=0: STATE=IDLE, TRIG_ENABLE=0, RUN_START=0, all counters 0, DONE=0, DRAIN_TIMEOUT=0, latched config 0.
REQ-035 Reset asserted mid-run SHALL return the block to IDLE immediately, with no RUN_START pulse and no DONE.
REQ-036 Reset deassertion SHALL be synchronised to CLK40 inside the block.

Structure
REQ-037 Package tlu_run_pkg SHALL hold the state encoding constants and the default widths.
REQ-038 Sub-module tlu_sat_counter (clear, enable, saturating, parameterised width) SHALL be instantiated for the trigger, time and drain counters.

Verification
REQ-039 MAX_TRIGGERS=3, RUN_TIME=0; START then 3 TRIG_PULSEs -> RUN_START pulses once, RUN ends 1 cycle after the 3rd pulse, RUN_TRIG_CNT=3, DONE=1 once DATA_EMPTY=1 and all enabled channels are ready.
REQ-040 RUN_TIME=100, MAX_TRIGGERS=0 -> TRIG_ENABLE high for exactly 100 cycles, RUN_TIME_CNT=100.
REQ-041 DRAIN_TIMEOUT=10, EN_OUTPUT=000001, DUT_READY[0]=0 held -> IDLE after 10 DRAIN cycles, DRAIN_TIMEOUT=1, DONE=1.
REQ-042 CMD_START and CMD_STOP in the same RUN cycle -> DRAIN, no second RUN_START.
REQ-043 RST_N low for 1 cycle during RUN with RUN_TRIG_CNT=5 -> STATE=0, TRIG_ENABLE=0, counters 0, DONE=0.
REQ-044 MAX_TRIGGERS changed from 3 to 1 during RUN -> run still stops at 3 triggers.
